// File: rtl/aha_clock_select_ctrl.sv
// aha_clock_select_ctrl: drives the shared SELECT bus of the glitch-free
// clock-switch slices and sequences each switch on the always-on CLK.
// Ports: CLK/RESETn reference clock and async active-low reset;
//   REQ_VALID/REQ_SEL/REQ_READY switch request handshake;
//   EN_IN slice enables (async to CLK); SELECT bus to slices;
//   CUR_SEL last committed source; BUSY switch in progress;
//   DONE one-cycle completion pulse; ERR sticky {bad select, timeout};
//   ERR_CLR clears ERR (a same-cycle set wins).
module aha_clock_select_ctrl #(
    parameter int NUM_CLKS    = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int RESET_SEL   = 0
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                REQ_VALID,
    input  logic [2:0]          REQ_SEL,
    output logic                REQ_READY,
    input  logic [NUM_CLKS-1:0] EN_IN,
    output logic [2:0]          SELECT,
    output logic [2:0]          CUR_SEL,
    output logic                BUSY,
    output logic                DONE,
    output logic [1:0]          ERR,
    input  logic                ERR_CLR
);
    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_OFF,
        S_ON
    } state_t;

    localparam logic [2:0]          RSEL   = 3'(RESET_SEL);
    localparam logic [3:0]          NCLK   = 4'(NUM_CLKS);
    localparam logic [15:0]         TO_MAX = 16'(TIMEOUT);
    localparam logic [15:0]         TO_M1  = 16'(TIMEOUT - 1);
    localparam logic [NUM_CLKS-1:0] ONE    = NUM_CLKS'(1);

    state_t              state;
    logic [15:0]         cnt;
    logic [NUM_CLKS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CLKS-1:0] en_s;
    logic [NUM_CLKS-1:0] tgt_oh;
    logic [NUM_CLKS-1:0] old_oh;
    logic                off_ok;
    logic                on_ok;
    logic                expire;
    logic                accept;
    logic                bad_sel;
    logic                timeout;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= EN_IN;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign en_s   = sync_q[SYNC_STAGES-1];
    // SELECT always holds the target of the phase in progress
    assign tgt_oh = ONE << SELECT;
    assign old_oh = ONE << CUR_SEL;
    assign off_ok = (en_s & old_oh) == '0;
    assign on_ok  = en_s == tgt_oh;

    // counter holds TIMEOUT-1 in the cycle that completes the budget
    assign expire  = cnt >= TO_M1;
    assign accept  = REQ_VALID && (state == S_IDLE);
    assign bad_sel = accept && ({1'b0, REQ_SEL} >= NCLK);
    assign timeout = expire && (
        ((state == S_INIT) && !on_ok) ||
        ((state == S_OFF)  && !off_ok) ||
        ((state == S_ON)   && !on_ok));

    assign REQ_READY = state == S_IDLE;
    assign BUSY      = state != S_IDLE;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= S_INIT;
            SELECT  <= RSEL;
            CUR_SEL <= RSEL;
            DONE    <= 1'b0;
            cnt     <= '0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                S_INIT: begin
                    if (on_ok) begin
                        state <= S_IDLE;
                    end else if (timeout) begin
                        CUR_SEL <= SELECT;
                        cnt     <= TO_MAX;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            bad_sel: begin
                            end
                            (REQ_SEL == CUR_SEL): begin
                                DONE <= 1'b1;
                            end
                            default: begin
                                SELECT <= REQ_SEL;
                                cnt    <= '0;
                                state  <= S_OFF;
                            end
                        endcase
                    end
                end
                S_OFF: begin
                    if (off_ok) begin
                        cnt   <= '0;
                        state <= S_ON;
                    end else if (timeout) begin
                        CUR_SEL <= SELECT;
                        cnt     <= TO_MAX;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_ON: begin
                    if (on_ok) begin
                        CUR_SEL <= SELECT;
                        DONE    <= 1'b1;
                        state   <= S_IDLE;
                    end else if (timeout) begin
                        CUR_SEL <= SELECT;
                        cnt     <= TO_MAX;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            ERR <= 2'b00;
        else
            ERR <= (ERR & ~{2{ERR_CLR}}) | {bad_sel, timeout};
    end

endmodule

// File: tb/tb_aha_clock_select_ctrl.sv
// tb_aha_clock_select_ctrl: randomized bench with a behavioural slice model
// and a transaction-level reference of the switch outcome.
module tb_aha_clock_select_ctrl;
    localparam int NC = 6;
    localparam int SS = 2;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [2:0]    req_sel = 3'd0;
    logic          req_ready;
    logic [NC-1:0] en_in = '0;
    logic [2:0]    sel;
    logic [2:0]    cur_sel;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic          err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    // slice model state
    int owner = -1;
    int dly = 0;
    int off_dly = 1;
    int on_dly = 2;
    bit block_off = 1'b0;
    bit block_on = 1'b1;

    // reference state
    int         m_cur = 0;
    logic [1:0] m_err = 2'b00;

    aha_clock_select_ctrl #(
        .NUM_CLKS   (NC),
        .SYNC_STAGES(SS),
        .TIMEOUT    (TO),
        .RESET_SEL  (0)
    ) dut (
        .CLK      (clk),
        .RESETn   (rst_n),
        .REQ_VALID(req_valid),
        .REQ_SEL  (req_sel),
        .REQ_READY(req_ready),
        .EN_IN    (en_in),
        .SELECT   (sel),
        .CUR_SEL  (cur_sel),
        .BUSY     (busy),
        .DONE     (done),
        .ERR      (err),
        .ERR_CLR  (err_clr)
    );

    always #5 clk = ~clk;

    // slices: the old one releases off_dly cycles after SELECT moves,
    // the new one takes over on_dly cycles after nothing is enabled
    initial forever begin
        @(posedge clk);
        #2;
        if (owner >= 0 && owner != int'(sel)) begin
            if (!block_off) begin
                if (dly >= off_dly) begin
                    en_in[owner] = 1'b0;
                    owner = -1;
                    dly = 0;
                end else dly++;
            end
        end else if (owner < 0) begin
            if (!block_on) begin
                if (dly >= on_dly) begin
                    en_in[sel] = 1'b1;
                    owner = int'(sel);
                    dly = 0;
                end else dly++;
            end
        end else dly = 0;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // waits at negedges for REQ_READY; lat = edges since the start point
    task automatic wait_idle(input int bound, input logic [2:0] exp_sel,
                             output int lat, output int dones,
                             output bit sel_ok);
        lat = 0;
        dones = int'(done);
        sel_ok = (sel === exp_sel);
        while (!req_ready && lat < bound) begin
            req_valid = 1'($urandom_range(0, 1));
            req_sel = 3'($urandom_range(0, 7));
            @(negedge clk);
            lat++;
            dones += int'(done);
            if (sel !== exp_sel) sel_ok = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    task automatic settle();
        block_off = 1'b0;
        block_on = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 2'b00;
        check("clr_err", err, m_err);
    endtask

    // mode: 0 normal, 1 old slice stuck on, 2 new slice never rises
    task automatic do_req(input logic [2:0] s, input int mode,
                          input bit clr, input int d1, input int d2);
        int  lat;
        int  dones;
        bit  sok;
        bit  real_sw;
        real_sw = (s < NC) && (int'(s) != m_cur);
        @(negedge clk);
        off_dly = d1;
        on_dly = d2;
        block_off = real_sw && mode == 1;
        block_on = real_sw && mode == 2;
        req_valid = 1'b1;
        req_sel = s;
        err_clr = clr;
        @(negedge clk);
        req_valid = 1'b0;
        err_clr = 1'b0;
        if (clr) m_err = 2'b00;
        if (s >= NC) begin
            m_err[1] = 1'b1;
            check("bad_err", err, m_err);
            check("bad_done", done, 0);
            check("bad_sel", sel, m_cur);
            check("bad_cur", cur_sel, m_cur);
            check("bad_rdy", req_ready, 1);
        end else if (!real_sw) begin
            check("noop_done", done, 1);
            check("noop_busy", busy, 0);
            check("noop_sel", sel, m_cur);
            check("noop_err", err, m_err);
            @(negedge clk);
            check("noop_pulse", done, 0);
        end else begin
            check("sw_sel", sel, s);
            check("sw_busy", busy, 1);
            check("sw_rdy", req_ready, 0);
            check("sw_done0", done, 0);
            wait_idle(200, s, lat, dones, sok);
            check("sw_stable", sok, 1);
            check("sw_rdy_end", req_ready, 1);
            check("sw_cur", cur_sel, s);
            m_cur = int'(s);
            if (mode == 0) begin
                check("sw_dones", dones, 1);
                check("sw_done_at_idle", done, 1);
                check("sw_lat_min", lat >= 2*SS+2, 1);
                check("sw_lat_max", lat <= d1+d2+2*SS+4, 1);
                check("sw_err", err, m_err);
                @(negedge clk);
                check("sw_pulse", done, 0);
            end else begin
                m_err[0] = 1'b1;
                check("to_err", err, m_err);
                check("to_dones", dones, 0);
                if (mode == 1)
                    check("to_lat_off", lat, TO);
                else
                    check("to_lat_on",
                          lat >= TO+SS+2 && lat <= TO+d1+2*SS+2, 1);
                settle();
            end
        end
    endtask

    initial begin
        int  lat;
        int  dones;
        bit  sok;
        logic [2:0] s;
        int  r;

        // reset state
        #12;
        check("rst_sel", sel, 0);
        check("rst_cur", cur_sel, 0);
        check("rst_rdy", req_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // bring-up: slice 0 rises after 3 cycles
        @(negedge clk);
        rst_n = 1'b1;
        block_on = 1'b0;
        wait_idle(40, 3'd0, lat, dones, sok);
        check("init_rdy", req_ready, 1);
        check("init_lat", lat <= 3+SS+1, 1);
        check("init_done", dones, 0);
        check("init_sel", sel, 0);
        check("init_err", err, 0);

        do_req(3'd3, 0, 1'b0, 4, 5);
        do_req(3'd3, 0, 1'b0, 1, 1);
        do_req(3'd7, 0, 1'b0, 1, 1);
        clear_err();
        do_req(3'd2, 2, 1'b0, 2, 2);
        clear_err();
        do_req(3'd5, 1, 1'b0, 2, 2);
        do_req(3'd6, 0, 1'b1, 1, 1);

        // reset in the middle of OFF
        s = (m_cur == 4) ? 3'd5 : 3'd4;
        @(negedge clk);
        block_off = 1'b1;
        req_valid = 1'b1;
        req_sel = s;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_sel", sel, s);
        repeat (3) begin
            req_valid = 1'b1;
            req_sel = 3'd1;
            @(negedge clk);
            check("mid_ignore", sel, s);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", sel, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_rdy", req_ready, 0);
        check("mid_rst_err", err, 0);
        req_valid = 1'b0;
        block_off = 1'b0;
        m_cur = 0;
        m_err = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(60, 3'd0, lat, dones, sok);
        check("rec_rdy", req_ready, 1);
        check("rec_done", dones, 0);
        check("rec_cur", cur_sel, 0);
        check("rec_sel", sok, 1);

        for (int i = 0; i < 40; i++) begin
            s = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            do_req(s, (r == 0) ? 1 : (r == 1) ? 2 : 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(1, 4), $urandom_range(1, 4));
            if ($urandom_range(0, 5) == 0) clear_err();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
